accum_readout: RTL and testbench
================================

ACCUM_READOUT -- requirements
Module: accum_readout

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: number of wait cycles after each output_sel change before sampling; legal range 0..15.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low; low forces reset state immediately, independent of clock.
REQ-004 SHALL have port start, input, 1 bit: request one readout sequence; sampled only in IDLE.
REQ-005 SHALL have port acc_data, input, 8 bits: data_out of the adder/accumulator being read.
REQ-006 SHALL have port output_sel, output, 2 bits: drives the accumulator output_sel; encoded with the MUX_SEL_* values from mux_sel.vh.
REQ-007 SHALL have port busy, output, 1 bit: high from sequence start until the result handshake completes.
REQ-008 SHALL have port result, output, 32 bits: {carry byte, counter byte, reg2 MSB byte, reg2 LSB byte}.
REQ-009 SHALL have port result_valid, output, 1 bit: result is stable and offered.
REQ-010 SHALL have port result_ready, input, 1 bit: consumer accepts result.
REQ-011 SHALL have port dropped, output, 1 bit: sticky flag, set when start is high outside IDLE.
REQ-012 SHALL register all outputs; no combinational path from any input to any output.

Function
REQ-013 SHALL implement states IDLE, READ (byte index 0..3, settle counter 0..SETTLE_CYCLES) and PRESENT.
REQ-014 Byte order SHALL be:
- idx0 = MUX_SEL_REGISTER_2_LSB -> result[7:0]
- idx1 = MUX_SEL_REGISTER_2_MSB -> result[15:8]
- idx2 = MUX_SEL_COUNTER_VALUE -> result[23:16]
- idx3 = MUX_SEL_COUNTER_CARRY -> result[31:24]
REQ-015 IDLE with start=1 at edge N SHALL move to READ idx0, set busy=1, drive output_sel=REGISTER_2_LSB and load settle counter = SETTLE_CYCLES.
REQ-016 Each byte SHALL hold output_sel for SETTLE_CYCLES+1 cycles; byte k SHALL be captured from acc_data at edge N+(k+1)*(SETTLE_CYCLES+1).
REQ-017 output_sel SHALL switch to the next index on the same edge that captures the current byte.
REQ-018 The capture of idx3 SHALL enter PRESENT with result_valid=1 after edge N+4*(SETTLE_CYCLES+1) (latency 8 cycles at default).
REQ-019 In PRESENT, result and result_valid SHALL hold until an edge with result_ready=1; that edge SHALL clear result_valid and busy and return to IDLE.
REQ-020 result SHALL keep its last value in IDLE; it SHALL be overwritten bytewise only by captures.
REQ-021 On entering IDLE, output_sel SHALL return to MUX_SEL_REGISTER_2_LSB.
REQ-022 start high in READ or PRESENT SHALL be ignored and SHALL set dropped=1; this includes start and result_ready both high at the PRESENT exit edge.
REQ-023 start held high in IDLE SHALL start a new sequence on every IDLE edge, so back-to-back sequences occur one cycle apart.
REQ-024 result_ready outside PRESENT SHALL have no effect.
REQ-025 With SETTLE_CYCLES=0, one byte SHALL be captured per cycle and result_valid SHALL rise after edge N+4.

Reset
REQ-026 reset low SHALL force IDLE, busy=0, result_valid=0, result=32'h0, dropped=0 and output_sel=MUX_SEL_REGISTER_2_LSB, asynchronously, including mid-READ or mid-PRESENT.
REQ-027 After reset deasserts, the first clock edge SHALL be able to accept start.
REQ-028 dropped SHALL be cleared only by reset.

Verification
REQ-029 Bench model (acc_data by output_sel: LSB=8'h84, MSB=8'h00, COUNTER=8'h2C, CARRY=8'h01), default parameter, one start pulse -> output_sel steps LSB, MSB, COUNTER, CARRY holding 2 cycles each; result_valid after 8 edges; result=32'h012C0084.
REQ-030 result_ready held low 5 cycles after valid, then high one cycle -> result stable throughout; valid and busy drop on the ready edge; output_sel returns to LSB.
REQ-031 start pulsed during READ idx1 -> sequence unaffected and result unchanged; dropped=1 and stays 1 until reset.
REQ-032 reset asserted low between clock edges during READ idx2 -> busy, result_valid, result and dropped are immediately 0 and output_sel=LSB; next start gives a full correct sequence.
REQ-033 SETTLE_CYCLES=0 with start and result_ready held high and model values changed between runs -> results 1 cycle apart from each other in sequence timing, valid after 4 edges, each result matching the model values at capture time.
REQ-034 Integration with AdderAccumulator: load 8'h42, add, load 8'hEE, add, start -> result[15:0]=16'h0130 and the counter/carry bytes match the accumulator's own outputs.

Source files
------------

// File: rtl/accum_readout.sv
// accum_readout: steps output_sel through the four accumulator bytes, captures each one
// after a settle window, and offers the packed 32-bit word on a valid/ready handshake.
module accum_readout #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  acc_data,
  output logic [1:0]  output_sel,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        dropped
);

  localparam logic [1:0] MUX_SEL_REGISTER_2_LSB = 2'd0;
  localparam logic [1:0] MUX_SEL_REGISTER_2_MSB = 2'd1;
  localparam logic [1:0] MUX_SEL_COUNTER_VALUE  = 2'd2;
  localparam logic [1:0] MUX_SEL_COUNTER_CARRY  = 2'd3;
  localparam logic [3:0] SETTLE_LOAD            = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_PRESENT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
  logic       dropped_q, dropped_d;
  logic       capture;

  // Byte index to accumulator mux code; index order is also the result byte order.
  function automatic logic [1:0] sel_for_idx(input logic [1:0] idx);
    logic [1:0] sel;
    case (idx)
      2'd0:    sel = MUX_SEL_REGISTER_2_LSB;
      2'd1:    sel = MUX_SEL_REGISTER_2_MSB;
      2'd2:    sel = MUX_SEL_COUNTER_VALUE;
      default: sel = MUX_SEL_COUNTER_CARRY;
    endcase
    return sel;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      settle_q  <= 4'd0;
      sel_q     <= MUX_SEL_REGISTER_2_LSB;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    dropped_d = dropped_q | (start & (state_q != S_IDLE));
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_READ;
          idx_d    = 2'd0;
          settle_d = SETTLE_LOAD;
          sel_d    = sel_for_idx(2'd0);
          busy_d   = 1'b1;
        end
      end
      S_READ: begin
        if (settle_q == 4'd0) begin
          capture = 1'b1;
          if (idx_q == 2'd3) begin
            state_d = S_PRESENT;
            valid_d = 1'b1;
          end else begin
            // Advance the mux on the capture edge so the next byte starts settling at once.
            idx_d    = idx_q + 2'd1;
            settle_d = SETTLE_LOAD;
            sel_d    = sel_for_idx(idx_q + 2'd1);
          end
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_PRESENT: begin
        if (result_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          sel_d   = MUX_SEL_REGISTER_2_LSB;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One capture register per result byte; each only loads on its own index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [7:0] byte_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        byte_q <= 8'h00;
      end else if (capture && (idx_q == 2'(gi))) begin
        byte_q <= acc_data;
      end
    end
    assign result[gi*8 +: 8] = byte_q;
  end

  assign output_sel   = sel_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_accum_readout.sv
// Scoreboarded bench: two readout instances (settle 1 and settle 0) reading a bench-side
// accumulator model; expected words are queued at start and checked when valid rises.
module tb_accum_readout;

  localparam int S_A = 1;
  localparam int S_B = 0;
  localparam logic [1:0] SEL_LSB   = 2'd0;
  localparam logic [1:0] SEL_MSB   = 2'd1;
  localparam logic [1:0] SEL_CNT   = 2'd2;
  localparam logic [1:0] SEL_CARRY = 2'd3;

  typedef struct {
    logic [31:0] res;
    int          edge_n;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit done_b = 1'b0;
  bit drop_exp_a = 1'b0;

  logic [7:0]  mem_a [4];
  logic [7:0]  mem_b [4];
  logic [1:0]  sel_order [4];
  exp_t        qa [$];
  exp_t        qb [$];

  logic        rst_a, start_a, ready_a, busy_a, valid_a, dropped_a;
  logic [1:0]  sel_a;
  logic [7:0]  acc_a;
  logic [31:0] result_a;
  logic        rst_b, start_b, ready_b, busy_b, valid_b, dropped_b;
  logic [1:0]  sel_b;
  logic [7:0]  acc_b;
  logic [31:0] result_b;

  // Accumulator stand-in: presents the byte selected by output_sel.
  assign acc_a = mem_a[sel_a];
  assign acc_b = mem_b[sel_b];

  accum_readout #(.SETTLE_CYCLES(S_A)) dut_a (
    .clock(clock), .reset(rst_a), .start(start_a), .acc_data(acc_a),
    .output_sel(sel_a), .busy(busy_a), .result(result_a), .result_valid(valid_a),
    .result_ready(ready_a), .dropped(dropped_a)
  );

  accum_readout #(.SETTLE_CYCLES(S_B)) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b), .acc_data(acc_b),
    .output_sel(sel_b), .busy(busy_b), .result(result_b), .result_valid(valid_b),
    .result_ready(ready_b), .dropped(dropped_b)
  );

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack_word(input logic [7:0] m [4]);
    return {m[SEL_CARRY], m[SEL_CNT], m[SEL_MSB], m[SEL_LSB]};
  endfunction

  // One full readout on instance A: optional start pulse while reading, ready after a delay,
  // optional start on the exit edge.
  task automatic run_a(input int drop_t, input int ready_delay, input bit exit_start);
    exp_t e;
    e.res    = pack_word(mem_a);
    e.edge_n = cyc + 1;
    qa.push_back(e);
    start_a = 1'b1;
    for (int t = 0; t < 4 * (S_A + 1); t++) begin
      @(negedge clock);
      chk("read_sel", 32'(sel_a), 32'(sel_order[t / (S_A + 1)]));
      chk("read_busy", 32'(busy_a), 32'd1);
      chk("read_valid", 32'(valid_a), 32'd0);
      start_a = (t == drop_t);
      if (t == drop_t) drop_exp_a = 1'b1;
    end
    @(negedge clock);
    start_a = 1'b0;
    chk("valid_up", 32'(valid_a), 32'd1);
    for (int d = 0; d < ready_delay; d++) begin
      @(negedge clock);
      chk("hold_valid", 32'(valid_a), 32'd1);
      chk("hold_busy", 32'(busy_a), 32'd1);
      chk("hold_result", result_a, e.res);
    end
    ready_a = 1'b1;
    start_a = exit_start;
    if (exit_start) drop_exp_a = 1'b1;
    @(negedge clock);
    ready_a = 1'b0;
    start_a = 1'b0;
    chk("exit_valid", 32'(valid_a), 32'd0);
    chk("exit_busy", 32'(busy_a), 32'd0);
    chk("exit_sel", 32'(sel_a), 32'(SEL_LSB));
    chk("idle_result", result_a, e.res);
    @(negedge clock);
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("dropped_a", 32'(dropped_a), 32'(drop_exp_a));
  endtask

  // Monitor A
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clock);
      if (valid_a && !pv) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_valid: result %h with no pending request", result_a);
        end else begin
          e = qa.pop_front();
          chk("a_result", result_a, e.res);
          chk("a_latency", 32'(cyc), 32'(e.edge_n + 4 * (S_A + 1)));
        end
      end
      pv = valid_a;
    end
  end

  // Monitor B
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clock);
      if (valid_b && !pv) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_valid: result %h with no pending request", result_b);
        end else begin
          e = qb.pop_front();
          chk("b_result", result_b, e.res);
          chk("b_latency", 32'(cyc), 32'(e.edge_n + 4 * (S_B + 1)));
        end
      end
      pv = valid_b;
    end
  end

  // Instance B: start and ready held high, model bytes changed between runs.
  initial begin
    exp_t e;
    bit seen;
    start_b = 1'b0;
    ready_b = 1'b0;
    rst_b   = 1'b0;
    for (int i = 0; i < 4; i++) mem_b[i] = 8'($urandom);
    repeat (3) @(negedge clock);
    chk("b_reset_result", result_b, 32'h0);
    rst_b = 1'b1;
    @(negedge clock);
    e.res = pack_word(mem_b);
    e.edge_n = cyc + 1;
    qb.push_back(e);
    start_b = 1'b1;
    ready_b = 1'b1;
    for (int r = 0; r < 6; r++) begin
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (valid_b) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL b_timeout: no result_valid within 20 cycles on run %0d", r);
        break;
      end
      if (r == 5) begin
        start_b = 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) mem_b[i] = 8'($urandom);
        e.res = pack_word(mem_b);
        e.edge_n = cyc + 2;
        qb.push_back(e);
      end
    end
    start_b = 1'b0;
    repeat (4) @(negedge clock);
    chk("b_final_busy", 32'(busy_b), 32'd0);
    done_b = 1'b1;
  end

  // Instance A main sequence
  initial begin
    exp_t e;
    sel_order[0] = SEL_LSB;
    sel_order[1] = SEL_MSB;
    sel_order[2] = SEL_CNT;
    sel_order[3] = SEL_CARRY;
    rst_a   = 1'b0;
    start_a = 1'b0;
    ready_a = 1'b0;
    mem_a[SEL_LSB]   = 8'h84;
    mem_a[SEL_MSB]   = 8'h00;
    mem_a[SEL_CNT]   = 8'h2C;
    mem_a[SEL_CARRY] = 8'h01;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_result", result_a, 32'h0);
    chk("rst_dropped", 32'(dropped_a), 32'd0);
    chk("rst_sel", 32'(sel_a), 32'(SEL_LSB));

    // Start on the very first edge after reset release.
    rst_a = 1'b1;
    run_a(-1, 5, 1'b0);
    chk("model_word", result_a, 32'h012C0084);

    run_a(2, 1, 1'b0);
    chk("drop_word", result_a, 32'h012C0084);
    run_a(-1, 0, 1'b1);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) mem_a[i] = 8'($urandom);
      run_a(-1, int'($urandom_range(0, 3)), 1'b0);
    end

    // Asynchronous reset in the middle of reading byte 2.
    e.res = pack_word(mem_a);
    e.edge_n = cyc + 1;
    qa.push_back(e);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_sel", 32'(sel_a), 32'(SEL_CNT));
    #2 rst_a = 1'b0;
    #1;
    chk("async_busy", 32'(busy_a), 32'd0);
    chk("async_valid", 32'(valid_a), 32'd0);
    chk("async_result", result_a, 32'h0);
    chk("async_dropped", 32'(dropped_a), 32'd0);
    chk("async_sel", 32'(sel_a), 32'(SEL_LSB));
    qa.delete();
    drop_exp_a = 1'b0;
    @(negedge clock);
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) mem_a[i] = 8'($urandom);
    run_a(-1, 2, 1'b0);

    for (int k = 0; k < 2000; k++) begin
      if (done_b) break;
      @(negedge clock);
    end
    if (!done_b) begin
      checks++;
      errors++;
      $display("FAIL b_done_timeout: instance B sequence did not complete");
    end
    repeat (2) @(negedge clock);
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
